fifo_drain_arbiter: RTL and testbench

FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

---
 rtl/fifo_ctrl_pkg.sv | 14 +
 rtl/rr_pick.sv | 27 ++
 rtl/fifo_drain_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_drain_arbiter.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the FIFO read-side controllers: FSM encodings and default burst length.
package fifo_ctrl_pkg;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  localparam int unsigned DEFAULT_MAX_BURST = 16;

  // Width needed for a counter that can hold 0..max_val inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester strictly after last_grant, wrapping,
// so a sole requester equal to last_grant is picked again.
module rr_pick #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CH_WIDTH = 2
) (
  input  logic [NUM_CH-1:0]   req,
  input  logic [CH_WIDTH-1:0] last_grant,
  output logic [CH_WIDTH-1:0] grant,
  output logic                any_req
);

  always_comb begin
    grant   = last_grant;
    any_req = 1'b0;
    // Walk offsets 1..NUM_CH from last_grant; the first hit wins.
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      for (int unsigned j = 0; j < NUM_CH; j++) begin
        if (!any_req && req[j] && (((32'(last_grant) + off) % NUM_CH) == j)) begin
          grant   = CH_WIDTH'(j);
          any_req = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_CH FWFT FIFOs into one registered output stream, granting channels round-robin
// for bursts of up to MAX_BURST pops with one arbitration cycle between bursts.
module fifo_drain_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CH_WIDTH   = 2,
  parameter int unsigned MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                         read_clk,
  input  logic                         read_rst_n,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            fifo_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_CH-1:0]            fifo_read_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_WIDTH-1:0]          out_ch,
  output logic                         busy
);

  localparam int unsigned         CntW     = cnt_width(MAX_BURST);
  localparam logic [CntW-1:0]     CntLast  = CntW'(MAX_BURST - 1);
  localparam logic [CH_WIDTH-1:0] LastInit = CH_WIDTH'(NUM_CH - 1);

  logic                  r_state;
  logic [CH_WIDTH-1:0]   r_grant;
  logic [CH_WIDTH-1:0]   r_last_grant;
  logic [CntW-1:0]       r_burst_cnt;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CH_WIDTH-1:0]   r_out_ch;

  logic                  w_state_d;
  logic [CH_WIDTH-1:0]   w_grant_d;
  logic [CH_WIDTH-1:0]   w_last_grant_d;
  logic [CntW-1:0]       w_burst_cnt_d;

  logic [NUM_CH-1:0]     w_req;
  logic [CH_WIDTH-1:0]   w_pick_grant;
  logic                  w_any_req;
  logic                  w_en_g;
  logic                  w_empty_g;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_space;
  logic                  w_pop;
  logic                  w_burst_done;

  assign w_req = ch_enable & ~fifo_empty;

  rr_pick #(
    .NUM_CH  (NUM_CH),
    .CH_WIDTH(CH_WIDTH)
  ) u_rr_pick (
    .req       (w_req),
    .last_grant(r_last_grant),
    .grant     (w_pick_grant),
    .any_req   (w_any_req)
  );

  // Mux the granted channel's enable, empty flag and head word.
  always_comb begin
    w_en_g    = 1'b0;
    w_empty_g = 1'b1;
    w_head    = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (r_grant == CH_WIDTH'(i)) begin
        w_en_g    = ch_enable[i];
        w_empty_g = fifo_empty[i];
        w_head    = fifo_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_space = ~r_out_valid | out_ready;
  assign w_pop   = (r_state == ST_BURST) & w_space & w_en_g & ~w_empty_g;

  // A burst ends on its last pop, or when there is room but the grant cannot supply.
  assign w_burst_done = w_pop ? (r_burst_cnt == CntLast) : w_space;

  always_comb begin
    fifo_read_en = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      fifo_read_en[i] = w_pop & (r_grant == CH_WIDTH'(i));
    end
  end

  always_comb begin
    w_state_d      = r_state;
    w_grant_d      = r_grant;
    w_last_grant_d = r_last_grant;
    w_burst_cnt_d  = r_burst_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_d     = w_pick_grant;
          w_burst_cnt_d = '0;
          w_state_d     = ST_BURST;
        end
      end
      ST_BURST: begin
        if (w_pop) begin
          w_burst_cnt_d = r_burst_cnt + CntW'(1);
        end
        if (w_burst_done) begin
          w_state_d      = ST_IDLE;
          w_last_grant_d = r_grant;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= LastInit;
      r_burst_cnt  <= '0;
    end else begin
      r_state      <= w_state_d;
      r_grant      <= w_grant_d;
      r_last_grant <= w_last_grant_d;
      r_burst_cnt  <= w_burst_cnt_d;
    end
  end

  always_ff @(posedge read_clk or negedge read_rst_n) begin
    if (!read_rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
    end else if (w_pop) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_head;
      r_out_ch    <= r_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign busy      = (r_state == ST_BURST);

  // Pop strobe is one-hot and the burst counter never runs past the last pop slot.
  a_read_en_onehot : assert property (@(posedge read_clk) disable iff (!read_rst_n)
    $onehot0(fifo_read_en));
  a_burst_cnt_range : assert property (@(posedge read_clk) disable iff (!read_rst_n)
    (r_state == ST_BURST) |-> (r_burst_cnt <= CntLast));

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FIFO environment, queue-level reference model checked every
// cycle, directed scenarios with literal expectations, a random phase, and a MAX_BURST=1 instance.
module tb_fifo_drain_arbiter;

  localparam int unsigned DW    = 32;
  localparam int unsigned NCH   = 4;
  localparam int unsigned MB    = 16;
  localparam int unsigned DEPTH = 4096;

  logic              read_clk = 1'b0;
  logic              read_rst_n;
  logic [NCH-1:0]    ch_enable;
  logic [NCH-1:0]    fifo_empty;
  logic [NCH*DW-1:0] fifo_data;
  logic [NCH-1:0]    fifo_read_en;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_ch;
  logic              busy;

  logic [1:0]        b_enable;
  logic [1:0]        b_empty;
  logic [2*DW-1:0]   b_data;
  logic [1:0]        b_read_en;
  logic              b_valid;
  logic              b_ready;
  logic [DW-1:0]     b_out_data;
  logic              b_out_ch;
  logic              b_busy;

  always #5 read_clk = ~read_clk;

  fifo_drain_arbiter #(
    .DATA_WIDTH(DW), .NUM_CH(NCH), .CH_WIDTH(2), .MAX_BURST(MB)
  ) u_dut (
    .read_clk(read_clk), .read_rst_n(read_rst_n), .ch_enable(ch_enable),
    .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_read_en(fifo_read_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .busy(busy)
  );

  fifo_drain_arbiter #(
    .DATA_WIDTH(DW), .NUM_CH(2), .CH_WIDTH(1), .MAX_BURST(1)
  ) u_dut_mb1 (
    .read_clk(read_clk), .read_rst_n(read_rst_n), .ch_enable(b_enable),
    .fifo_empty(b_empty), .fifo_data(b_data), .fifo_read_en(b_read_en),
    .out_valid(b_valid), .out_ready(b_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .busy(b_busy)
  );

  // FIFO environment
  logic [DW-1:0] fmem [NCH][DEPTH];
  logic [11:0]   fhead [NCH];
  logic [11:0]   ftail [NCH];
  logic [NCH-1:0] sampled_pop;
  int            pop_cnt [NCH];
  int            first_pop;
  int            b_head [2];
  int            b_lim;
  logic [1:0]    b_sampled;

  // Reference model state
  bit            m_busy, m_ov;
  logic [1:0]    m_grant, m_last, m_och;
  int            m_cnt;
  logic [DW-1:0] m_od;

  int            n_checks, n_pass;
  int            log_n;
  logic [1:0]    acc_ch [512];
  int            b_log_n;
  logic          b_acc_ch [64];
  logic [DW-1:0] b_acc_data [64];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit m_req(input logic [1:0] c);
    return ch_enable[c] && (fhead[c] != ftail[c]);
  endfunction

  task automatic model_reset();
    m_busy = 1'b0; m_ov = 1'b0; m_grant = 2'd0; m_last = 2'(NCH - 1);
    m_cnt = 0; m_och = 2'd0; m_od = '0;
  endtask

  function automatic logic [NCH-1:0] model_pop_vec();
    logic [NCH-1:0] v;
    v = '0;
    if (m_busy && (!m_ov || out_ready) && m_req(m_grant)) v[m_grant] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    logic [NCH-1:0] pv;
    logic [1:0]     c;
    pv = model_pop_vec();
    if (!m_busy) begin
      for (int k = 1; k <= int'(NCH); k++) begin
        c = 2'((int'(m_last) + k) % NCH);
        if (!m_busy && m_req(c)) begin
          m_grant = c; m_cnt = 0; m_busy = 1'b1;
        end
      end
      if (out_ready) m_ov = 1'b0;
    end else if (pv != '0) begin
      m_od = fmem[m_grant][fhead[m_grant]];
      m_och = m_grant; m_ov = 1'b1; m_cnt++;
      if (m_cnt == int'(MB)) begin m_busy = 1'b0; m_last = m_grant; end
    end else begin
      if (!m_ov || out_ready) begin m_busy = 1'b0; m_last = m_grant; end
      if (out_ready) m_ov = 1'b0;
    end
  endtask

  function automatic bit quiet();
    bit r;
    r = !m_busy && !m_ov;
    for (int i = 0; i < int'(NCH); i++) if (m_req(2'(i))) r = 1'b0;
    return r;
  endfunction

  // Compare process: outputs are stable at the falling edge.
  always @(negedge read_clk) begin
    logic [NCH-1:0] exp_pop;
    if (!read_rst_n) begin
      model_reset();
      check("rst_read_en", fifo_read_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      sampled_pop = '0;
    end else begin
      exp_pop = model_pop_vec();
      check("busy", busy, m_busy);
      check("read_en", fifo_read_en, exp_pop);
      check("out_valid", out_valid, m_ov);
      if (m_ov) begin
        check("out_data", out_data, m_od);
        check("out_ch", out_ch, m_och);
      end
      sampled_pop = fifo_read_en;
      for (int i = 0; i < int'(NCH); i++) begin
        if (fifo_read_en[i]) begin
          pop_cnt[i]++;
          if (first_pop < 0) first_pop = i;
        end
      end
      if (out_valid && out_ready) begin
        if (log_n < 512) acc_ch[log_n] = out_ch;
        log_n++;
      end
      model_step();
    end
    b_sampled = b_read_en;
    if (b_valid && b_ready) begin
      if (b_log_n < 64) begin
        b_acc_ch[b_log_n] = b_out_ch;
        b_acc_data[b_log_n] = b_out_data;
      end
      b_log_n++;
    end
  end

  task automatic drive_ports();
    for (int i = 0; i < int'(NCH); i++) begin
      fifo_empty[i] = (fhead[i] == ftail[i]);
      fifo_data[i*DW +: DW] = fmem[i][fhead[i]];
    end
    for (int i = 0; i < 2; i++) begin
      b_empty[i] = (b_head[i] >= b_lim);
      b_data[i*DW +: DW] = 32'((i << 16) | b_head[i]);
    end
  endtask

  task automatic tick();
    @(posedge read_clk);
    #1;
    for (int i = 0; i < int'(NCH); i++) if (sampled_pop[i]) fhead[i]++;
    for (int i = 0; i < 2; i++) if (b_sampled[i]) b_head[i]++;
    sampled_pop = '0;
    b_sampled = '0;
    drive_ports();
  endtask

  task automatic push(input int c, input int n);
    for (int k = 0; k < n; k++) begin
      fmem[c][ftail[c]] = (32'(c) << 24) | 32'(ftail[c]);
      ftail[c]++;
    end
    drive_ports();
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      tick();
      done = quiet();
    end
    check(name, done, 1);
  endtask

  initial begin
    int base1, base3, exp_c;
    bit found;
    logic [DW-1:0] stall_word;
    n_checks = 0; n_pass = 0; log_n = 0; b_log_n = 0; first_pop = -1;
    for (int i = 0; i < int'(NCH); i++) begin fhead[i] = '0; ftail[i] = '0; pop_cnt[i] = 0; end
    b_head[0] = 0; b_head[1] = 0; b_lim = 0; b_ready = 1'b1; b_enable = 2'b00;
    sampled_pop = '0; b_sampled = '0;
    read_rst_n = 1'b0; ch_enable = '0; out_ready = 1'b0;
    model_reset();
    drive_ports();
    repeat (3) tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_ch", out_ch, 0);
    check("reset_busy", busy, 0);
    read_rst_n = 1'b1;

    // All four channels loaded, free-flowing output.
    log_n = 0;
    for (int c = 0; c < int'(NCH); c++) push(c, 40);
    ch_enable = 4'hF; out_ready = 1'b1;
    wait_idle("s1_drain", 400);
    check("s1_count", log_n, 160);
    for (int k = 0; k < 160; k++) begin
      exp_c = (k < 128) ? (k / 16) % 4 : (k - 128) / 8;
      check("s1_order", acc_ch[k], exp_c);
    end

    // Only ch2 holds 5 words.
    log_n = 0;
    push(2, 5);
    wait_idle("s2_drain", 50);
    check("s2_count", log_n, 5);
    for (int k = 0; k < 5; k++) check("s2_ch", acc_ch[k], 2);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s2_idle_busy", busy, 0);
      check("s2_idle_read_en", fifo_read_en, 0);
    end

    // Backpressure for 10 cycles mid-burst.
    log_n = 0;
    base3 = int'(fhead[0]);
    push(0, 20);
    for (int n = 0; n < 50 && log_n < 4; n++) tick();
    check("s3_reached", log_n, 4);
    out_ready = 1'b0;
    stall_word = fmem[0][base3 + 4];
    for (int k = 0; k < 10; k++) begin
      tick();
      check("s3_hold_valid", out_valid, 1);
      check("s3_hold_data", out_data, stall_word);
      check("s3_hold_read_en", fifo_read_en, 0);
      check("s3_hold_busy", busy, 1);
    end
    out_ready = 1'b1;
    wait_idle("s3_drain", 100);
    check("s3_count", log_n, 20);

    // ch1 disabled after 3 pops.
    log_n = 0;
    base1 = pop_cnt[1];
    push(1, 10); push(2, 4);
    for (int n = 0; n < 50 && (pop_cnt[1] - base1) < 3; n++) tick();
    ch_enable[1] = 1'b0;
    wait_idle("s4_drain", 100);
    repeat (10) tick();
    check("s4_ch1_pops", pop_cnt[1] - base1, 3);
    check("s4_count", log_n, 7);
    check("s4_first_ch1", acc_ch[0], 1);
    check("s4_next_ch2", acc_ch[3], 2);
    check("s4_parked_busy", busy, 0);
    ch_enable[1] = 1'b1;
    wait_idle("s4_reenable", 100);
    check("s4_ch1_total", pop_cnt[1] - base1, 10);

    // Reset mid-burst with a word in the output register.
    push(3, 10);
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin tick(); found = out_valid; end
    check("s5_valid_seen", found, 1);
    #2 read_rst_n = 1'b0;
    #1;
    check("s5_rst_valid", out_valid, 0);
    check("s5_rst_data", out_data, 0);
    check("s5_rst_read_en", fifo_read_en, 0);
    repeat (2) tick();
    push(0, 5);
    first_pop = -1;
    read_rst_n = 1'b1;
    wait_idle("s5_drain", 100);
    check("s5_first_grant", first_pop, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      tick();
      if ($urandom_range(3) == 0) begin
        int c;
        c = int'($urandom_range(NCH - 1));
        if (int'(ftail[c]) < int'(DEPTH) - 16) push(c, int'($urandom_range(1, 6)));
      end
      if ($urandom_range(15) == 0) ch_enable = 4'($urandom) | 4'($urandom);
      out_ready = ($urandom_range(9) < 7);
    end
    ch_enable = 4'hF; out_ready = 1'b1;
    wait_idle("rand_drain", 2000);
    for (int c = 0; c < int'(NCH); c++) check("rand_empty", fhead[c], ftail[c]);

    // MAX_BURST=1, two channels: strict alternation.
    b_lim = 8; b_enable = 2'b11; b_log_n = 0;
    drive_ports();
    for (int n = 0; n < 200 && b_log_n < 16; n++) tick();
    check("mb1_count", b_log_n, 16);
    for (int k = 0; k < 16; k++) begin
      check("mb1_ch", b_acc_ch[k], k % 2);
      check("mb1_data", b_acc_data[k], ((k % 2) << 16) | (k / 2));
    end
    repeat (4) tick();
    check("mb1_idle", b_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
